// File: rtl/prio_queue_pkg.sv
// Shared definitions for the sorted-register priority queue and its PHOLD event format.
package prio_queue_pkg;

  localparam int unsigned DATA_W_DFLT = 16;
  localparam int unsigned DEPTH_DFLT  = 16;
  localparam int unsigned CNT_W_DFLT  = 5;

  // Event word layout: {timestamp, lp_id}; the whole word is the sort key.
  localparam int unsigned TS_W   = 13;
  localparam int unsigned LP_W   = 3;
  localparam int unsigned TS_LSB = 3;

  typedef enum logic [1:0] {
    ModeIdle,
    ModeInsert,
    ModeRemove,
    ModeReplace
  } mode_e;

  function automatic logic [TS_W+LP_W-1:0] make_event(input logic [TS_W-1:0] ts,
                                                      input logic [LP_W-1:0] lp);
    return {ts, lp};
  endfunction

endpackage

// File: rtl/prio_queue_cell.sv
// One slot of the insertion shift register plus its key comparator.
module prio_queue_cell
  import prio_queue_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter bit          Bottom = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  mode_e             mode_i,
  input  logic [DATA_W-1:0] inp_data_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] lower_data_i,
  input  logic              lower_le_i,
  input  logic [DATA_W-1:0] upper_data_i,
  input  logic              upper_le_i,
  output logic [DATA_W-1:0] data_o,
  output logic              le_o
);

  logic [DATA_W-1:0] slot_q, slot_d;

  // Valid slots with key <= input form a prefix of the array; new entry lands just past it.
  assign le_o   = valid_i && (slot_q <= inp_data_i);
  assign data_o = slot_q;

  always_comb begin
    slot_d = slot_q;
    unique case (mode_i)
      ModeIdle: ;
      ModeInsert: begin
        if (!le_o) slot_d = (Bottom || lower_le_i) ? inp_data_i : lower_data_i;
      end
      ModeRemove: slot_d = upper_data_i;
      ModeReplace: begin
        // Head leaves, so compare against the upper neighbour to find the new slot.
        if (upper_le_i)           slot_d = upper_data_i;
        else if (Bottom || le_o)  slot_d = inp_data_i;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) slot_q <= '0;
    else         slot_q <= slot_d;
  end

endmodule

// File: rtl/prio_queue.sv
// Min-priority queue as a sorted register array; head continuously on out_data.
// Optional status outputs (full/empty/sticky overflow) under PRIO_QUEUE_STATUS_EN.
module prio_queue
  import prio_queue_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned DEPTH  = DEPTH_DFLT,
  parameter int unsigned CNT_W  = CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq,
  input  logic              deq,
  input  logic [DATA_W-1:0] inp_data,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
`ifdef PRIO_QUEUE_STATUS_EN
  ,
  output logic              full,
  output logic              empty,
  output logic              overflow
`endif
);

  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] slot [DEPTH];
  logic [DEPTH-1:0]  le;
  logic [DEPTH-1:0]  valid;
  logic              is_full, is_empty, enq_ok, deq_ok;
  mode_e             mode;

  assign is_full  = (count_q == DepthCnt);
  assign is_empty = (count_q == '0);
  // A full queue still accepts enq when paired with deq; deq on empty is dropped.
  assign enq_ok   = enq && (!is_full || deq);
  assign deq_ok   = deq && !is_empty;

  always_comb begin
    mode    = ModeIdle;
    count_d = count_q;
    case ({enq_ok, deq_ok})
      2'b11: mode = ModeReplace;
      2'b10: begin
        mode    = ModeInsert;
        count_d = count_q + 1'b1;
      end
      2'b01: begin
        mode    = ModeRemove;
        count_d = count_q - 1'b1;
      end
      default: mode = ModeIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [DATA_W-1:0] lower_data, upper_data;
    logic              lower_le, upper_le;

    if (i == 0) begin : g_bot
      assign lower_data = '0;
      assign lower_le   = 1'b0;
    end else begin : g_mid_lo
      assign lower_data = slot[i-1];
      assign lower_le   = le[i-1];
    end

    if (i == DEPTH - 1) begin : g_top
      assign upper_data = '0;
      assign upper_le   = 1'b0;
    end else begin : g_mid_hi
      assign upper_data = slot[i+1];
      assign upper_le   = le[i+1];
    end

    assign valid[i] = (CNT_W'(i) < count_q);

    prio_queue_cell #(
      .DATA_W (DATA_W),
      .Bottom (i == 0)
    ) u_cell (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mode_i       (mode),
      .inp_data_i   (inp_data),
      .valid_i      (valid[i]),
      .lower_data_i (lower_data),
      .lower_le_i   (lower_le),
      .upper_data_i (upper_data),
      .upper_le_i   (upper_le),
      .data_o       (slot[i]),
      .le_o         (le[i])
    );
  end

  assign out_data = is_empty ? '0 : slot[0];
  assign count    = count_q;

`ifdef PRIO_QUEUE_STATUS_EN
  logic overflow_q, overflow_d;

  assign overflow_d = overflow_q | (enq && !deq && is_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign full     = is_full;
  assign empty    = is_empty;
  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_prio_queue.sv
// Directed self-checking bench for prio_queue (default parameters, 16 x 16-bit).
module tb_prio_queue;
  import prio_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enq = 1'b0;
  logic        deq = 1'b0;
  logic [15:0] inp_data = '0;
  logic [15:0] out_data;
  logic [4:0]  count;
`ifdef PRIO_QUEUE_STATUS_EN
  logic        full, empty, overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prio_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq      (enq),
    .deq      (deq),
    .inp_data (inp_data),
    .out_data (out_data),
    .count    (count)
`ifdef PRIO_QUEUE_STATUS_EN
    ,
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of controls, then sample 1 time unit after the edge.
  task automatic step(input logic e, input logic d, input logic [15:0] din);
    enq      = e;
    deq      = d;
    inp_data = din;
    @(posedge clk);
    #1;
    enq      = 1'b0;
    deq      = 1'b0;
    inp_data = '0;
  endtask

  logic [15:0] drain_exp [16];

  initial begin
    drain_exp = '{16'h11, 16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h17, 16'h18,
                  16'h18, 16'h19, 16'h1A, 16'h1B, 16'h1C, 16'h1D, 16'h1E, 16'h1F};

    // Reset and idle
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_head", 32'(out_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_head", 32'(out_data), 32'h0);
`ifdef PRIO_QUEUE_STATUS_EN
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_full", 32'(full), 32'd0);
`endif

    // Deq on empty is ignored
    step(1'b0, 1'b1, 16'h0);
    chk("deq_empty_count", 32'(count), 32'd0);
    chk("deq_empty_head", 32'(out_data), 32'h0);

    // Enq 3,1,2,0 then four deqs
    step(1'b1, 1'b0, 16'h0003);
    chk("enq3_head", 32'(out_data), 32'h3);
    step(1'b1, 1'b0, 16'h0001);
    chk("enq1_head", 32'(out_data), 32'h1);
    step(1'b1, 1'b0, 16'h0002);
    chk("enq2_head", 32'(out_data), 32'h1);
    step(1'b1, 1'b0, 16'h0000);
    chk("enq0_head", 32'(out_data), 32'h0);
    chk("enq4_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("small_drain_head", 32'(out_data), 32'(i));
      chk("small_drain_count", 32'(count), 32'(4 - i));
      step(1'b0, 1'b1, 16'h0);
    end
    chk("small_drained_count", 32'(count), 32'd0);
    chk("small_drained_head", 32'(out_data), 32'h0);

    // Fill in reverse order, then overflow attempt
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'(31 - i));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_head", 32'(out_data), 32'h10);
`ifdef PRIO_QUEUE_STATUS_EN
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf_clear", 32'(overflow), 32'd0);
`endif
    step(1'b1, 1'b0, 16'h0005);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_head", 32'(out_data), 32'h10);
`ifdef PRIO_QUEUE_STATUS_EN
    chk("ovf_flag", 32'(overflow), 32'd1);
`endif

    // Replace while full: 0x10 leaves, 0x18 joins after the existing 0x18
    step(1'b1, 1'b1, 16'h0018);
    chk("full_repl_count", 32'(count), 32'd16);
    chk("full_repl_head", 32'(out_data), 32'h11);
    for (int i = 0; i < 16; i++) begin
      chk("drain_head", 32'(out_data), 32'(drain_exp[i]));
      step(1'b0, 1'b1, 16'h0);
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_head_empty", 32'(out_data), 32'h0);
`ifdef PRIO_QUEUE_STATUS_EN
    chk("ovf_sticky", 32'(overflow), 32'd1);
`endif

    // Simultaneous enq+deq with two entries
    step(1'b1, 1'b0, 16'h0008);
    step(1'b1, 1'b0, 16'h0020);
    chk("pair_head", 32'(out_data), 32'h8);
    step(1'b1, 1'b1, 16'h0010);
    chk("repl_head", 32'(out_data), 32'h10);
    chk("repl_count", 32'(count), 32'd2);
    step(1'b0, 1'b1, 16'h0);
    chk("repl_next_head", 32'(out_data), 32'h20);
    chk("repl_next_count", 32'(count), 32'd1);
    step(1'b0, 1'b1, 16'h0);
    chk("repl_done_count", 32'(count), 32'd0);

    // enq+deq on empty behaves as a plain enq
    step(1'b1, 1'b1, 16'h0007);
    chk("repl_empty_count", 32'(count), 32'd1);
    chk("repl_empty_head", 32'(out_data), 32'h7);
    step(1'b0, 1'b1, 16'h0);

    // Equal keys retained
    step(1'b1, 1'b0, 16'h0048);
    step(1'b1, 1'b0, 16'h0048);
    step(1'b1, 1'b0, 16'h0040);
    chk("dup_count", 32'(count), 32'd3);
    chk("dup_head0", 32'(out_data), 32'h40);
    step(1'b0, 1'b1, 16'h0);
    chk("dup_head1", 32'(out_data), 32'h48);
    step(1'b0, 1'b1, 16'h0);
    chk("dup_head2", 32'(out_data), 32'h48);
    step(1'b0, 1'b1, 16'h0);
    chk("dup_done_count", 32'(count), 32'd0);

    // Event-format keys: earlier timestamp wins, then lower LP id
    step(1'b1, 1'b0, make_event(13'd20, 3'd1));
    step(1'b1, 1'b0, make_event(13'd10, 3'd5));
    step(1'b1, 1'b0, make_event(13'd10, 3'd2));
    chk("evt_count", 32'(count), 32'd3);
    chk("evt_head", 32'(out_data), 32'(make_event(13'd10, 3'd2)));

    // Asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_head", 32'(out_data), 32'h0);
`ifdef PRIO_QUEUE_STATUS_EN
    chk("async_rst_ovf", 32'(overflow), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 16'h0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_head", 32'(out_data), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
